ss_map_sequencer: RTL

- Synchronous controller that decides which world map (part_1, lr, loop) the game and video paths read.
- Watches the player X location for edge crossings and defers each map swap to the next vertical-blank start, so a frame never mixes two maps.
- Holds off world-map reads while the dual-port BRAM outputs settle, then tells game logic to reload the player X at the opposite edge.
- Its map_sel output drives the map read-data mux in the sidescroller top level.

---
 rtl/ss_map_sequencer_if.sv | 26 ++
 rtl/ss_map_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ss_map_sequencer_if.sv
// Signal bundle between game/video logic and the map sequencer.
// The master drives position and vsync; the slave returns map selection and reload controls.
interface ss_map_sequencer_if #(
  parameter int MAP_SEL_W = 2
);
  logic                 vsync_start;
  logic [7:0]           loc_x;
  logic                 loc_valid;
  logic                 map_loop_en;
  logic [MAP_SEL_W-1:0] map_sel;
  logic                 map_busy;
  logic                 map_data_valid;
  logic                 locx_load;
  logic [7:0]           locx_load_val;
  logic [7:0]           switch_count;

  modport master (
    output vsync_start, loc_x, loc_valid, map_loop_en,
    input  map_sel, map_busy, map_data_valid, locx_load, locx_load_val, switch_count
  );

  modport slave (
    input  vsync_start, loc_x, loc_valid, map_loop_en,
    output map_sel, map_busy, map_data_valid, locx_load, locx_load_val, switch_count
  );
endinterface

// File: rtl/ss_map_sequencer.sv
// World-map sequencer: detects player edge crossings and swaps the map at the next vblank.
// After a swap it waits for BRAM data to settle, then requests a player X reload.
module ss_map_sequencer #(
  parameter int         NUM_MAPS      = 3,
  parameter int         MAP_SEL_W     = 2,
  parameter logic [7:0] EDGE_RIGHT    = 8'h7C,
  parameter logic [7:0] EDGE_LEFT     = 8'h00,
  parameter logic [7:0] SPAWN_LEFT    = 8'h01,
  parameter logic [7:0] SPAWN_RIGHT   = 8'h7B,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic               clk_75,
  input logic               reset,
  ss_map_sequencer_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [MAP_SEL_W-1:0] LAST_MAP   = MAP_SEL_W'(NUM_MAPS - 1);
  localparam logic [CNT_W-1:0]     SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, SETTLE, RELOAD} state_t;

  state_t               state;
  state_t               next_state;
  logic [7:0]           loc_x_q;
  logic [MAP_SEL_W-1:0] map_sel_q;
  logic [MAP_SEL_W-1:0] target;
  logic                 dir;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 map_busy_q;
  logic                 map_data_valid_q;
  logic                 locx_load_q;
  logic [7:0]           locx_load_val_q;
  logic [7:0]           switch_count_q;

  logic                 rise_r;
  logic                 rise_l;
  logic                 accept;
  logic [MAP_SEL_W-1:0] accept_target;

  // Only a fresh arrival at an edge counts, and only while nothing else is in flight.
  always_comb begin
    rise_r        = 1'b0;
    rise_l        = 1'b0;
    accept        = 1'b0;
    accept_target = map_sel_q;
    if (state == IDLE && bus.loc_valid) begin
      rise_r = (bus.loc_x == EDGE_RIGHT) && (loc_x_q != EDGE_RIGHT);
      rise_l = (bus.loc_x == EDGE_LEFT)  && (loc_x_q != EDGE_LEFT);
    end
    if (rise_r) begin
      if (map_sel_q < LAST_MAP) begin
        accept        = 1'b1;
        accept_target = map_sel_q + 1'b1;
      end else if (bus.map_loop_en) begin
        accept        = 1'b1;
        accept_target = '0;
      end
    end else if (rise_l && map_sel_q != '0) begin
      accept        = 1'b1;
      accept_target = map_sel_q - 1'b1;
    end
  end

  always_ff @(posedge clk_75 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)              next_state = PENDING;
      PENDING: if (bus.vsync_start)     next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_END) next_state = RELOAD;
      RELOAD:                           next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk_75 or negedge reset) begin
    if (!reset) begin
      loc_x_q          <= EDGE_LEFT;
      map_sel_q        <= '0;
      target           <= '0;
      dir              <= 1'b0;
      settle_cnt       <= '0;
      map_busy_q       <= 1'b0;
      map_data_valid_q <= 1'b1;
      locx_load_q      <= 1'b0;
      locx_load_val_q  <= SPAWN_LEFT;
      switch_count_q   <= '0;
    end else begin
      if (bus.loc_valid) loc_x_q <= bus.loc_x;
      if (state == IDLE && accept) begin
        target <= accept_target;
        dir    <= rise_r;
      end
      if (state == PENDING && bus.vsync_start) begin
        map_sel_q  <= target;
        settle_cnt <= '0;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      if (state == RELOAD) switch_count_q <= switch_count_q + 8'd1;
      map_busy_q       <= (next_state != IDLE);
      map_data_valid_q <= (next_state != SETTLE);
      locx_load_q      <= (next_state == RELOAD);
      if (next_state == RELOAD) locx_load_val_q <= dir ? SPAWN_LEFT : SPAWN_RIGHT;
    end
  end

  assign bus.map_sel        = map_sel_q;
  assign bus.map_busy       = map_busy_q;
  assign bus.map_data_valid = map_data_valid_q;
  assign bus.locx_load      = locx_load_q;
  assign bus.locx_load_val  = locx_load_val_q;
  assign bus.switch_count   = switch_count_q;

endmodule
